// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-write bundle between a program source and the IMem loader.
// The master drives the byte stream and start request; the slave (the loader) answers
// with flow control, the IF-stage write port and status.
interface imem_loader_if;
    logic        load_start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] w_ins;
    logic [31:0] w_addr;
    logic        we;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output load_start, rx_data, rx_valid,
        input  rx_ready, w_ins, w_addr, we, cpu_rst, busy, done, error
    );

    modport slave (
        input  load_start, rx_data, rx_valid,
        output rx_ready, w_ins, w_addr, we, cpu_rst, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed byte stream, packs big-endian
// 32-bit words and writes them through the IF stage port while holding the CPU in reset.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input logic          clk,
    input logic          rst,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        BYTE,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  len_hi;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [31:0] w_ins_q;
    logic [31:0] w_addr_q;

    logic [15:0] len_in;
    logic        len_too_big;
    logic        last_word;
    logic        accept;

    assign len_in      = {len_hi, bus.rx_data};
    assign len_too_big = 32'(len_in) > DEPTH_WORDS;
    assign last_word   = (word_idx + 16'd1) == n_words;
    assign accept      = bus.rx_valid && bus.rx_ready;

    assign bus.w_ins   = w_ins_q;
    assign bus.w_addr  = w_addr_q;

    // State register; reset drops any load in progress straight back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and Moore outputs; flow control and status depend on state only.
    always_comb begin
        state_next   = state;
        bus.rx_ready = 1'b0;
        bus.we       = 1'b0;
        bus.busy     = 1'b1;
        bus.cpu_rst  = 1'b1;
        bus.done     = 1'b0;
        bus.error    = 1'b0;
        case (state)
            IDLE: begin
                bus.busy    = 1'b0;
                bus.cpu_rst = 1'b0;
                if (bus.load_start) begin
                    state_next = LEN_HI;
                end
            end
            LEN_HI: begin
                bus.rx_ready = 1'b1;
                if (bus.rx_valid) begin
                    state_next = LEN_LO;
                end
            end
            LEN_LO: begin
                bus.rx_ready = 1'b1;
                if (bus.rx_valid) begin
                    if (len_too_big) begin
                        state_next = ERR;
                    end else if (len_in == 16'd0) begin
                        state_next = DONE;
                    end else begin
                        state_next = BYTE;
                    end
                end
            end
            BYTE: begin
                bus.rx_ready = 1'b1;
                if (bus.rx_valid && byte_cnt == 2'd3) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                bus.we     = 1'b1;
                state_next = last_word ? DONE : BYTE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                bus.busy  = 1'b0;
                bus.error = 1'b1;
                if (bus.load_start) begin
                    state_next = LEN_HI;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture the length, shift bytes in MSB first, and latch the completed
    // word and its address so they stay stable for the whole write cycle and afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_hi   <= 8'd0;
            n_words  <= 16'd0;
            word_idx <= 16'd0;
            byte_cnt <= 2'd0;
            shift    <= 24'd0;
            w_ins_q  <= 32'd0;
            w_addr_q <= 32'd0;
        end else begin
            case (state)
                LEN_HI: begin
                    if (accept) begin
                        len_hi <= bus.rx_data;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        n_words  <= len_in;
                        byte_cnt <= 2'd0;
                        word_idx <= 16'd0;
                    end
                end
                BYTE: begin
                    if (accept) begin
                        shift    <= {shift[15:0], bus.rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            w_ins_q  <= {shift, bus.rx_data};
                            w_addr_q <= {14'd0, word_idx, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 16'd1;
                    byte_cnt <= 2'd0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: frames are turned into expected
// (address, word) writes by a byte-order model, and a monitor matches every WE pulse.
`timescale 1ns/1ps
module tb_imem_loader;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] ins;
    } wr_t;

    logic clk = 1'b0;
    logic rst;

    imem_loader_if bus();

    imem_loader #(.DEPTH_WORDS(256)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int  compared   = 0;
    int  mismatched = 0;
    int  cyc        = 0;
    int  doneSeen   = 0;
    int  doneCyc    = 0;
    wr_t expQ[$];
    wr_t monExp;
    logic prevDone  = 1'b0;

    always @(posedge clk) cyc++;

    task automatic checkEq(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, required %b", name, actual, expected);
        end
    endtask

    // Monitor: pops an expected write on every WE and checks the Done/CPU_RST sequencing.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.we) begin
                checkBit("rx_ready_in_write", bus.rx_ready, 1'b0);
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_we: got write addr %h ins %h, required none",
                             bus.w_addr, bus.w_ins);
                end else begin
                    monExp = expQ.pop_front();
                    checkEq("w_addr", bus.w_addr, monExp.addr);
                    checkEq("w_ins", bus.w_ins, monExp.ins);
                end
            end
            if (bus.done) begin
                doneSeen++;
                doneCyc = cyc;
                checkBit("cpu_rst_during_done", bus.cpu_rst, 1'b1);
            end
            if (prevDone) begin
                checkBit("done_single_cycle", bus.done, 1'b0);
                checkBit("cpu_rst_after_done", bus.cpu_rst, 1'b0);
                checkBit("busy_after_done", bus.busy, 1'b0);
            end
            prevDone = bus.done;
        end else begin
            prevDone = 1'b0;
        end
    end

    function automatic byte_q_t makeFrame(input int n, input bit withData);
        byte_q_t q;
        logic [15:0] len;
        len = 16'(n);
        q.push_back(len[15:8]);
        q.push_back(len[7:0]);
        if (withData) begin
            for (int i = 0; i < 4 * n; i++) begin
                q.push_back(8'($urandom_range(0, 255)));
            end
        end
        return q;
    endfunction

    // Entered and left just after a rising edge; raises Load_Start with the first byte already valid.
    task automatic applyStimulus(input logic [7:0] firstByte, output int startCyc);
        bus.load_start = 1'b1;
        bus.rx_valid   = 1'b1;
        bus.rx_data    = firstByte;
        startCyc       = cyc;
        @(negedge clk);
        checkBit("ready_low_before_start", bus.rx_ready, 1'b0);
        @(posedge clk);
        #1;
        bus.load_start = 1'b0;
        checkBit("cpu_rst_on_start", bus.cpu_rst, 1'b1);
        checkBit("busy_on_start", bus.busy, 1'b1);
        checkBit("ready_on_start", bus.rx_ready, 1'b1);
        checkBit("error_cleared_on_start", bus.error, 1'b0);
    endtask

    task automatic sendBytes(input byte_q_t frame, input int count, input int gapPct, input bit spurious);
        int idx    = 0;
        int budget = 0;
        while (idx < count && budget < 20000) begin
            bus.load_start = spurious && ($urandom_range(0, 99) < 10);
            if (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
                bus.rx_valid = 1'b0;
            end else begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = frame[idx];
            end
            @(negedge clk);
            if (bus.rx_valid && bus.rx_ready) idx++;
            @(posedge clk);
            #1;
            budget++;
        end
        bus.rx_valid   = 1'b0;
        bus.load_start = 1'b0;
        checkEq("bytes_sent", idx, count);
    endtask

    // Predicts the writes of one frame from its byte order, drives it and checks completion.
    task automatic checkOutput(input byte_q_t frame, input int gapPct, input bit spurious);
        int n;
        int startCyc;
        int doneBefore;
        wr_t w;
        n = int'({frame[0], frame[1]});
        if (n <= 256) begin
            for (int i = 0; i < n; i++) begin
                w.addr = 32'(4 * i);
                w.ins  = {frame[2 + 4*i], frame[3 + 4*i], frame[4 + 4*i], frame[5 + 4*i]};
                expQ.push_back(w);
            end
        end
        doneBefore = doneSeen;
        applyStimulus(frame[0], startCyc);
        if (n > 256) begin
            sendBytes(frame, 2, gapPct, 1'b0);
            repeat (4) begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = 8'hAA;
                @(negedge clk);
                checkBit("err_error", bus.error, 1'b1);
                checkBit("err_cpu_rst", bus.cpu_rst, 1'b1);
                checkBit("err_rx_ready", bus.rx_ready, 1'b0);
                checkBit("err_busy", bus.busy, 1'b0);
                @(posedge clk);
                #1;
            end
            bus.rx_valid = 1'b0;
            checkEq("no_done_on_error", doneSeen - doneBefore, 0);
        end else begin
            sendBytes(frame, frame.size(), gapPct, spurious);
            for (int b = 0; b < 400 && doneSeen == doneBefore; b++) @(posedge clk);
            #1;
            checkEq("done_pulses", doneSeen - doneBefore, 1);
            if (gapPct == 0) checkEq("done_latency", doneCyc - startCyc, 3 + 5 * n);
            @(negedge clk);
            checkBit("cpu_rst_released", bus.cpu_rst, 1'b0);
            checkEq("writes_pending", expQ.size(), 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        byte_q_t f;
        rst            = 1'b1;
        bus.load_start = 1'b0;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkBit("reset_rx_ready", bus.rx_ready, 1'b0);
        checkBit("reset_we", bus.we, 1'b0);
        checkBit("reset_cpu_rst", bus.cpu_rst, 1'b0);
        checkBit("reset_busy", bus.busy, 1'b0);
        checkBit("reset_done", bus.done, 1'b0);
        checkBit("reset_error", bus.error, 1'b0);
        checkEq("reset_w_ins", bus.w_ins, 32'h0);
        checkEq("reset_w_addr", bus.w_addr, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] nominal two-word frame");
        f = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        checkOutput(f, 0, 1'b0);

        $display("[TB] same frame with random gaps");
        checkOutput(f, 40, 1'b0);

        $display("[TB] zero-length frame");
        f = '{8'h00, 8'h00};
        checkOutput(f, 0, 1'b0);

        $display("[TB] oversize frame then recovery");
        f = '{8'h01, 8'h01};
        checkOutput(f, 0, 1'b0);
        f = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        checkOutput(f, 0, 1'b0);

        $display("[TB] random frames");
        for (int k = 0; k < 10; k++) begin
            f = makeFrame(int'($urandom_range(0, 5)), 1'b1);
            checkOutput(f, ($urandom_range(0, 1) == 1) ? 30 : 0, 1'($urandom_range(0, 1)));
        end
        f = makeFrame(257 + int'($urandom_range(0, 65000)), 1'b0);
        checkOutput(f, 0, 1'b0);

        $display("[TB] full-depth frame");
        f = makeFrame(256, 1'b1);
        checkOutput(f, 0, 1'b1);

        $display("[TB] abort after six data bytes");
        f = makeFrame(2, 1'b1);
        begin
            wr_t w;
            int  sc;
            w.addr = 32'h0;
            w.ins  = {f[2], f[3], f[4], f[5]};
            expQ.push_back(w);
            applyStimulus(f[0], sc);
            sendBytes(f, 8, 0, 1'b0);
        end
        #2;
        rst = 1'b1;
        #1;
        checkBit("abort_rx_ready", bus.rx_ready, 1'b0);
        checkBit("abort_we", bus.we, 1'b0);
        checkBit("abort_cpu_rst", bus.cpu_rst, 1'b0);
        checkBit("abort_busy", bus.busy, 1'b0);
        checkBit("abort_done", bus.done, 1'b0);
        checkBit("abort_error", bus.error, 1'b0);
        checkEq("abort_w_ins", bus.w_ins, 32'h0);
        checkEq("abort_w_addr", bus.w_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkEq("abort_writes_pending", expQ.size(), 0);
        checkBit("abort_cpu_rst_idle", bus.cpu_rst, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
